// File: rtl/dmem_arbiter.sv
// Purpose: two-port (core, debug) arbiter in front of a single-port data memory, with starvation guard for debug.
// Latency: zero-cycle grant and memory strobes; read data returns one cycle after the grant with rvalid to the owner.
// Backpressure: a requester holds req until gnt; the losing port simply sees gnt=0 and retries next cycle.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 9,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        starve_cnt
);

   typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   owner_t            owner;
   logic              d_win;
   logic [DATA_W-1:0] c_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   // Grant decision and memory mux: core wins unless debug is alone or has waited STARVE_LIM cycles.
   always_comb begin
      d_win     = d_req && (!c_req || (starve_cnt == LIM));
      c_gnt     = !reset && c_req && !d_win;
      d_gnt     = !reset && d_win;
      // With no grant the core-side address/data stay on the bus; only the strobes go quiet.
      mem_addr  = d_gnt ? d_addr  : c_addr;
      mem_wdata = d_gnt ? d_wdata : c_wdata;
      mem_wr    = (c_gnt && c_we)  || (d_gnt && d_we);
      mem_rd    = (c_gnt && !c_we) || (d_gnt && !d_we);
   end

   // Read return: the registered owner tag selects who sees this cycle's mem_rdata; reset squashes an in-flight read.
   always_comb begin
      c_rvalid = !reset && (owner == OWN_CORE);
      d_rvalid = !reset && (owner == OWN_DBG);
      c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
      d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
   end

   // Sequential state: starvation counter, read owner tag and held read data per port.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= 4'd0;
         owner      <= OWN_NONE;
         c_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (d_gnt || !d_req)
            starve_cnt <= 4'd0;
         else if (starve_cnt < LIM)
            starve_cnt <= starve_cnt + 4'd1;

         if (c_gnt && !c_we)
            owner <= OWN_CORE;
         else if (d_gnt && !d_we)
            owner <= OWN_DBG;
         else
            owner <= OWN_NONE;

         if (c_rvalid)
            c_rdata_q <= mem_rdata;
         if (d_rvalid)
            d_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with STARVE_LIM=3 backed by a memory model,
// and a second with STARVE_LIM=1 sharing the request inputs to show alternating grants.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [8:0]  c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;

   logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wr, mem_rd;
   logic [31:0] c_rdata, d_rdata, mem_wdata;
   logic [31:0] mem_rdata;
   logic [8:0]  mem_addr;
   logic [3:0]  starve_cnt;

   logic        u1_c_gnt, u1_c_rvalid, u1_d_gnt, u1_d_rvalid, u1_mem_wr, u1_mem_rd;
   logic [31:0] u1_c_rdata, u1_d_rdata, u1_mem_wdata;
   logic [8:0]  u1_mem_addr;
   logic [3:0]  u1_starve_cnt;
   logic [31:0] zero_rdata = 32'd0;

   logic [31:0] mem [0:511];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .STARVE_LIM(3)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
   );

   dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .STARVE_LIM(1)) dut_lim1 (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(u1_c_gnt), .c_rvalid(u1_c_rvalid), .c_rdata(u1_c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(u1_d_gnt), .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
      .mem_wr(u1_mem_wr), .mem_rd(u1_mem_rd), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
      .mem_rdata(zero_rdata), .starve_cnt(u1_starve_cnt)
   );

   // Single-port synchronous memory model: write in the strobe cycle, read data the cycle after.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven there and checked 1ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'h000; c_wdata = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h000; d_wdata = 32'h0;

      // Reset, two cycles with both ports requesting
      #1;
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_u1_gnt", {u1_c_gnt, u1_d_gnt, u1_mem_rd, u1_mem_wr}, 0);
      next_cycle();
      chk("rst2_c_gnt", c_gnt, 0);
      chk("rst2_d_gnt", d_gnt, 0);
      chk("rst2_strobes", {mem_rd, mem_wr}, 0);
      chk("rst2_starve", starve_cnt, 0);
      chk("rst2_rvalid", {c_rvalid, d_rvalid}, 0);
      chk("rst2_rdata", {c_rdata, d_rdata}, 0);
      chk("rst2_u1_state", {u1_starve_cnt, u1_c_rvalid, u1_d_rvalid}, 0);
      chk("rst2_u1_rdata", {u1_c_rdata | u1_d_rdata}, 0);
      chk("rst2_u1_mem_bus", {u1_mem_addr, u1_mem_wdata}, 0);

      // Contention: both write continuously; LIM=3 gives C,C,C,D,C and LIM=1 alternates
      next_cycle();
      reset = 1'b0;
      c_we = 1'b1; c_addr = 9'h020; c_wdata = 32'hAAAA0000;
      d_we = 1'b1; d_addr = 9'h021; d_wdata = 32'hBBBB0000;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) next_cycle();
         #1;
         chk($sformatf("cont%0d_c_gnt", k), c_gnt, (k != 3));
         chk($sformatf("cont%0d_d_gnt", k), d_gnt, (k == 3));
         chk($sformatf("cont%0d_starve", k), starve_cnt, (k == 4) ? 0 : k);
         chk($sformatf("cont%0d_mem_addr", k), mem_addr, (k == 3) ? 9'h021 : 9'h020);
         chk($sformatf("cont%0d_lim1_c_gnt", k), u1_c_gnt, (k % 2 == 0));
         chk($sformatf("cont%0d_lim1_d_gnt", k), u1_d_gnt, (k % 2 == 1));
         chk($sformatf("cont%0d_lim1_starve", k), u1_starve_cnt, (k % 2));
      end

      // Idle: no grant, core address/data on the bus, strobes quiet
      next_cycle();
      c_req = 1'b0; d_req = 1'b0;
      c_addr = 9'h033; c_wdata = 32'h0000C0DE; d_addr = 9'h044; d_wdata = 32'h0000DEAD;
      #1;
      chk("idle_gnt", {c_gnt, d_gnt}, 0);
      chk("idle_strobes", {mem_rd, mem_wr}, 0);
      chk("idle_mem_addr", mem_addr, 9'h033);
      chk("idle_mem_wdata", mem_wdata, 32'h0000C0DE);
      chk("idle_starve", starve_cnt, 1);

      // Lone debug write preloads 0xDEADBEEF at 0x05
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h005; d_wdata = 32'hDEADBEEF;
      #1;
      chk("dwr_d_gnt", d_gnt, 1);
      chk("dwr_strobes", {mem_wr, mem_rd}, 2'b10);
      chk("dwr_mem_addr", mem_addr, 9'h005);
      chk("dwr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("dwr_starve", starve_cnt, 0);

      // Core read of 0x05
      next_cycle();
      d_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
      #1;
      chk("crd_c_gnt", c_gnt, 1);
      chk("crd_mem_rd", mem_rd, 1);
      chk("crd_rvalid_early", c_rvalid, 0);
      next_cycle();
      c_req = 1'b0;
      #1;
      chk("crd_c_rvalid", c_rvalid, 1);
      chk("crd_c_rdata", c_rdata, 32'hDEADBEEF);
      chk("crd_d_rvalid", d_rvalid, 0);
      next_cycle();
      #1;
      chk("crd_rvalid_drop", c_rvalid, 0);
      chk("crd_rdata_hold", c_rdata, 32'hDEADBEEF);

      // Debug read of 0x05 returns to the debug port only
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h005;
      #1;
      chk("drd_d_gnt", d_gnt, 1);
      next_cycle();
      d_req = 1'b0;
      #1;
      chk("drd_d_rvalid", d_rvalid, 1);
      chk("drd_d_rdata", d_rdata, 32'hDEADBEEF);
      chk("drd_c_rvalid", c_rvalid, 0);

      // Back-to-back: core read 0x10, debug write 0x11, core read 0x11
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
      #1;
      chk("b2b0_c_gnt", c_gnt, 1);
      chk("b2b0_mem_addr", mem_addr, 9'h010);
      next_cycle();
      c_req = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h011; d_wdata = 32'h12345678;
      #1;
      chk("b2b1_d_gnt", d_gnt, 1);
      chk("b2b1_mem_addr", mem_addr, 9'h011);
      chk("b2b1_mem_wr", mem_wr, 1);
      chk("b2b1_c_rvalid", c_rvalid, 1);
      next_cycle();
      d_req = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'h011;
      #1;
      chk("b2b2_c_gnt", c_gnt, 1);
      chk("b2b2_mem_addr", mem_addr, 9'h011);
      chk("b2b2_mem_rd", mem_rd, 1);
      chk("b2b2_no_rvalid_after_write", {c_rvalid, d_rvalid}, 0);
      next_cycle();
      c_req = 1'b0;
      #1;
      chk("b2b3_c_rvalid", c_rvalid, 1);
      chk("b2b3_c_rdata", c_rdata, 32'h12345678);

      // Reset mid-read: read granted, reset next cycle squashes the response
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
      #1;
      chk("rmr_c_gnt", c_gnt, 1);
      next_cycle();
      reset = 1'b1;
      #1;
      chk("rmr_rst_c_rvalid", c_rvalid, 0);
      chk("rmr_rst_c_gnt", c_gnt, 0);
      chk("rmr_rst_mem_rd", mem_rd, 0);
      next_cycle();
      reset = 1'b0; c_req = 1'b0;
      #1;
      chk("rmr_post_c_rvalid", c_rvalid, 0);
      chk("rmr_post_c_rdata", c_rdata, 0);
      next_cycle();
      c_req = 1'b1; c_addr = 9'h011;
      #1;
      chk("rmr_again_c_gnt", c_gnt, 1);
      next_cycle();
      c_req = 1'b0;
      #1;
      chk("rmr_again_c_rvalid", c_rvalid, 1);
      chk("rmr_again_c_rdata", c_rdata, 32'h12345678);

      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, data word width.
- ADDR_W, default 9, word address width of the data memory.
- STARVE_LIM, default 4, range 1..15; the number of debug-port wait cycles before the debug port takes priority.

REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  core access request; held until granted.
- c_we  in  1  core write (1) or read (0).
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug/loader port; same meaning as the core inputs.
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  debug port; same meaning as the core outputs.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.
- starve_cnt  out  4  current debug wait count, for observation.

Function
REQ-003 The block SHALL grant at most one request per cycle; c_gnt and d_gnt are never both 1.
REQ-004 Default priority SHALL go to the core: if both ports request and starve_cnt < STARVE_LIM, c_gnt=1 and d_gnt=0.
REQ-005 If d_req=1 and starve_cnt == STARVE_LIM, d_gnt SHALL be 1 in that cycle regardless of c_req.
REQ-006 A lone requester SHALL be granted in the same cycle (zero-cycle arbitration latency).
REQ-007 starve_cnt SHALL be updated each cycle as follows:
- increment by 1 when d_req=1 and d_gnt=0;
- saturate at STARVE_LIM;
- clear to 0 when d_gnt=1 or d_req=0.
REQ-008 Memory outputs SHALL follow the grant combinationally in the grant cycle:
- mem_addr and mem_wdata from the granted port;
- mem_wr equals the granted port's we;
- mem_rd equals the inverse of the granted port's we;
- both strobes are 0 when there is no grant.
REQ-009 When no port is granted, mem_addr and mem_wdata SHALL hold the core-port values, and the strobes SHALL be 0.
REQ-010 A registered owner tag SHALL record which port, if any, issued a read in cycle N.
REQ-011 In cycle N+1 exactly the owning port's rvalid SHALL be 1, and its rdata SHALL equal mem_rdata.
REQ-012 Writes SHALL complete in the grant cycle and never raise rvalid.
REQ-013 Back-to-back grants SHALL be supported with no bubble cycle: a read response in cycle N+1 coexists with a new grant in N+1, to either port.
REQ-014 c_rdata and d_rdata SHALL present mem_rdata whenever their own rvalid is 1; otherwise they SHALL hold their last valid value.
REQ-015 The block SHALL NOT check requester protocol: a request dropped before grant is simply not served, and address or data changes while c_req or d_req is held are passed through as-is.

Reset
REQ-016 While reset=1, all grants and memory strobes SHALL be 0 in that same cycle, regardless of the request inputs.
REQ-017 The first rising edge with reset=1 SHALL set:
- starve_cnt=0;
- owner tag to none;
- c_rvalid=0 and d_rvalid=0;
- c_rdata=0 and d_rdata=0.
REQ-018 A read in flight when reset asserts SHALL be dropped, and no rvalid SHALL appear after reset for it.
REQ-019 Normal arbitration SHALL resume in the first cycle with reset=0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (STARVE_LIM=3 unless stated):
- Reset: assert reset for 2 cycles with c_req=d_req=1 -> c_gnt=d_gnt=0, mem_rd=mem_wr=0, starve_cnt=0, both rvalid=0.
- Core read: c_req=1, c_we=0, c_addr=0x05, memory holds 0xDEADBEEF at 0x05 -> c_gnt=1 and mem_rd=1 in cycle N; c_rvalid=1 and c_rdata=0xDEADBEEF in N+1; d_rvalid stays 0.
- Contention and starvation: c_req=d_req=1 held continuously -> c_gnt=1 for 3 cycles with starve_cnt 0,1,2; in the 4th cycle starve_cnt=3, d_gnt=1 and c_gnt=0; starve_cnt=0 the next cycle, and the core wins again.
- Back-to-back mixed traffic: core read 0x10, then debug write 0x11 with d_wdata=0x12345678, then core read 0x11 on consecutive cycles -> mem_addr sequence 0x10, 0x11, 0x11; the second core read returns 0x12345678; no idle cycle between grants.
- Reset mid-read: core read granted in cycle N, reset=1 in N+1 -> c_rvalid=0 in N+1 and N+2; the next read after reset returns correct data.
- Limit edge: STARVE_LIM=1, both ports requesting -> grants alternate core, debug, core, debug.
